// File: rtl/jt1943_romserve_pkg.sv
// Shared definitions for the ROM server: FSM encoding, client count and
// the round-robin successor helper.
package jt1943_romserve_pkg;

    localparam int NCLIENTS = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DATA    = 2'd2,
        DELIVER = 2'd3
    } rs_state_e;

    // Next client index after idx, wrapping 2 -> 0 (3 is treated as 2).
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/jt1943_rr_arb3.sv
// Combinational three-way round-robin arbiter: the search starts at ptr and
// the first requesting client found wins.
module jt1943_rr_arb3
    import jt1943_romserve_pkg::*;
(
    input  logic [NCLIENTS-1:0] req,
    input  logic [1:0]          ptr,
    output logic [NCLIENTS-1:0] gnt,
    output logic [1:0]          idx,
    output logic                any
);

    always_comb begin
        logic [1:0] cand;
        gnt  = '0;
        idx  = 2'd0;
        any  = 1'b0;
        // An out-of-range pointer restarts the search at client 0.
        cand = (ptr >= 2'd3) ? 2'd0 : ptr;
        for (int i = 0; i < NCLIENTS; i++) begin
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/jt1943_romserve.sv
// ROM request responder: arbitrates three cached ROM clients onto a single
// 32-bit SDRAM read port and returns each word with a cen-aligned strobe.
module jt1943_romserve
    import jt1943_romserve_pkg::*;
#(
    parameter int          AW0     = 18,
    parameter int          AW1     = 18,
    parameter int          AW2     = 18,
    parameter int          SW      = 22,
    parameter int unsigned OFFSET0 = 0,
    parameter int unsigned OFFSET1 = 'h10000,
    parameter int unsigned OFFSET2 = 'h20000
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           req0,
    input  logic [AW0-1:0] addr0,
    input  logic           req1,
    input  logic [AW1-1:0] addr1,
    input  logic           req2,
    input  logic [AW2-1:0] addr2,
    output logic [31:0]    dout,
    output logic           we0,
    output logic           we1,
    output logic           we2,
    output logic           sdram_req,
    output logic [SW-1:0]  sdram_addr,
    input  logic           sdram_ack,
    input  logic           data_rdy,
    input  logic [31:0]    data_read,
    output rs_state_e      dbg_state
);

    // Handshakes: sdram_req is raised at grant and held with a stable
    // sdram_addr until the one-cycle sdram_ack; data_rdy is honoured only in
    // WAIT (together with ack) or DATA; a client strobe weN stays high with a
    // stable dout until it has overlapped one cen=1 cycle, then drops.

    rs_state_e            state, state_nx;
    logic [1:0]           ptr, ptr_nx;
    logic [1:0]           gnt_idx, gnt_idx_nx;
    logic [NCLIENTS-1:0]  gnt_q, gnt_q_nx;
    logic [NCLIENTS-1:0]  we_q, we_nx;
    logic [31:0]          dout_nx;
    logic                 sdram_req_nx;
    logic [SW-1:0]        sdram_addr_nx;

    logic [NCLIENTS-1:0]  arb_gnt;
    logic [1:0]           arb_idx;
    logic                 arb_any;

    logic [SW-1:0]        word0, word1, word2, word_sel;
    logic                 unused_addr_bits;

    // Byte address to word address, zero-extended, then rebased; wraps mod 2^SW.
    assign word0 = SW'(OFFSET0) + SW'(addr0[AW0-1:2]);
    assign word1 = SW'(OFFSET1) + SW'(addr1[AW1-1:2]);
    assign word2 = SW'(OFFSET2) + SW'(addr2[AW2-1:2]);
    assign unused_addr_bits = ^{addr0[1:0], addr1[1:0], addr2[1:0]};

    always_comb begin
        word_sel = word0;
        case (arb_idx)
            2'd1:    word_sel = word1;
            2'd2:    word_sel = word2;
            default: word_sel = word0;
        endcase
    end

    jt1943_rr_arb3 u_arb (
        .req ({req2, req1, req0}),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        state_nx      = state;
        ptr_nx        = ptr;
        gnt_idx_nx    = gnt_idx;
        gnt_q_nx      = gnt_q;
        we_nx         = we_q;
        dout_nx       = dout;
        sdram_req_nx  = sdram_req;
        sdram_addr_nx = sdram_addr;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    gnt_idx_nx    = arb_idx;
                    gnt_q_nx      = arb_gnt;
                    sdram_addr_nx = word_sel;
                    sdram_req_nx  = 1'b1;
                    state_nx      = WAIT;
                end
            end
            WAIT: begin
                if (sdram_ack) begin
                    sdram_req_nx = 1'b0;
                    // A controller may answer in the same cycle it accepts.
                    if (data_rdy) begin
                        dout_nx  = data_read;
                        we_nx    = gnt_q;
                        state_nx = DELIVER;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (data_rdy) begin
                    dout_nx  = data_read;
                    we_nx    = gnt_q;
                    state_nx = DELIVER;
                end
            end
            DELIVER: begin
                if (cen) begin
                    we_nx    = '0;
                    ptr_nx   = rr_next(gnt_idx);
                    state_nx = IDLE;
                end
            end
            default: begin
                we_nx        = '0;
                sdram_req_nx = 1'b0;
                state_nx     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            gnt_idx    <= 2'd0;
            gnt_q      <= '0;
            we_q       <= '0;
            dout       <= 32'd0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            gnt_idx    <= gnt_idx_nx;
            gnt_q      <= gnt_q_nx;
            we_q       <= we_nx;
            dout       <= dout_nx;
            sdram_req  <= sdram_req_nx;
            sdram_addr <= sdram_addr_nx;
        end
    end

    assign we0       = we_q[0];
    assign we1       = we_q[1];
    assign we2       = we_q[2];
    assign dbg_state = state;

endmodule
